// File: rtl/ps2_pkg.sv
// ============================================================================
// ps2_pkg : shared Set-2 prefix/shift codes and decoder FSM encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_POP  = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/ps2_scan_decoder_if.sv
// ============================================================================
// ps2_scan_decoder_if : PS/2 receiver FIFO pop interface
// Rev 1.0
// ============================================================================
`default_nettype none

interface ps2_scan_decoder_if;

  logic       ready;
  logic [7:0] data;
  logic       overflow;
  logic       nextdata_n;

  modport master (
    output ready,
    output data,
    output overflow,
    input  nextdata_n
  );

  modport slave (
    input  ready,
    input  data,
    input  overflow,
    output nextdata_n
  );

endinterface

`default_nettype wire

// File: rtl/ps2_ascii_lut.sv
// ============================================================================
// ps2_ascii_lut : combinational Set-2 scan code to ASCII ROM
// Rev 1.0
// ============================================================================
`default_nettype none

module ps2_ascii_lut (
  input  logic [7:0] code,
  input  logic       ext,
  input  logic       shift,
  output logic [7:0] ascii
);

  logic [7:0] base;

  always_comb begin
    base = 8'h00;
    case (code)
      8'h1C: base = 8'h61;  8'h32: base = 8'h62;  8'h21: base = 8'h63;
      8'h23: base = 8'h64;  8'h24: base = 8'h65;  8'h2B: base = 8'h66;
      8'h34: base = 8'h67;  8'h33: base = 8'h68;  8'h43: base = 8'h69;
      8'h3B: base = 8'h6A;  8'h42: base = 8'h6B;  8'h4B: base = 8'h6C;
      8'h3A: base = 8'h6D;  8'h31: base = 8'h6E;  8'h44: base = 8'h6F;
      8'h4D: base = 8'h70;  8'h15: base = 8'h71;  8'h2D: base = 8'h72;
      8'h1B: base = 8'h73;  8'h2C: base = 8'h74;  8'h3C: base = 8'h75;
      8'h2A: base = 8'h76;  8'h1D: base = 8'h77;  8'h22: base = 8'h78;
      8'h35: base = 8'h79;  8'h1A: base = 8'h7A;
      8'h45: base = 8'h30;  8'h16: base = 8'h31;  8'h1E: base = 8'h32;
      8'h26: base = 8'h33;  8'h25: base = 8'h34;  8'h2E: base = 8'h35;
      8'h36: base = 8'h36;  8'h3D: base = 8'h37;  8'h3E: base = 8'h38;
      8'h46: base = 8'h39;
      8'h29: base = 8'h20;
      8'h5A: base = 8'h0D;
      default: base = 8'h00;
    endcase
  end

  always_comb begin
    ascii = base;
    // Only lowercase letters have an upper-case form; digits ignore shift.
    if (shift && (base >= 8'h61) && (base <= 8'h7A)) begin
      ascii = base - 8'h20;
    end
    if (ext) begin
      ascii = 8'h00;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ps2_scan_decoder.sv
// ============================================================================
// ps2_scan_decoder : pops Set-2 bytes from the PS/2 FIFO and emits key events
// Rev 1.0
// ============================================================================
`default_nettype none

module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  ps2_scan_decoder_if.slave  bus,
  output logic               key_valid,
  output logic [7:0]         key_code,
  output logic               key_ext,
  output logic               key_break,
  output logic               key_repeat,
  output logic [7:0]         ascii,
  output logic               shift,
  output logic [CNT_W-1:0]   press_count,
  output logic               err
);

  state_e             state_q, state_d;
  logic               nextdata_n_q, nextdata_n_d;
  logic [7:0]         byte_q, byte_d;
  logic               ext_q, ext_d, brk_q, brk_d;
  logic               held_v_q, held_v_d, held_ext_q, held_ext_d;
  logic [7:0]         held_code_q, held_code_d;
  logic               lsh_q, lsh_d, rsh_q, rsh_d;
  logic               key_valid_q, key_valid_d, key_ext_q, key_ext_d;
  logic               key_break_q, key_break_d, key_repeat_q, key_repeat_d;
  logic [7:0]         key_code_q, key_code_d;
  logic [CNT_W-1:0]   press_count_q, press_count_d;
  logic               err_q, err_d;
  logic               held_match;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.ready) state_d = ST_POP;
      ST_POP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // The pop strobe is registered, so it is low exactly during the POP cycle.
  always_comb begin
    nextdata_n_d = 1'b1;
    byte_d       = byte_q;
    if (state_q == ST_IDLE && bus.ready) begin
      nextdata_n_d = 1'b0;
      byte_d       = bus.data;
    end
  end

  assign held_match = held_v_q && (held_ext_q == ext_q) && (held_code_q == byte_q);

  // Classification of the popped byte, one byte per POP cycle.
  always_comb begin
    ext_d         = ext_q;
    brk_d         = brk_q;
    held_v_d      = held_v_q;
    held_ext_d    = held_ext_q;
    held_code_d   = held_code_q;
    lsh_d         = lsh_q;
    rsh_d         = rsh_q;
    key_valid_d   = 1'b0;
    key_code_d    = key_code_q;
    key_ext_d     = key_ext_q;
    key_break_d   = key_break_q;
    key_repeat_d  = key_repeat_q;
    press_count_d = press_count_q;
    err_d         = err_q | bus.overflow;
    if (state_q == ST_POP) begin
      if (byte_q == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (byte_q == PS2_BRK) begin
        brk_d = 1'b1;
      end else begin
        ext_d        = 1'b0;
        brk_d        = 1'b0;
        key_valid_d  = 1'b1;
        key_code_d   = byte_q;
        key_ext_d    = ext_q;
        key_break_d  = brk_q;
        key_repeat_d = 1'b0;
        if (!brk_q) begin
          if (held_match) begin
            key_repeat_d = 1'b1;
          end else begin
            press_count_d = press_count_q + CNT_W'(1);
            held_v_d      = 1'b1;
            held_ext_d    = ext_q;
            held_code_d   = byte_q;
          end
          if (!ext_q && byte_q == PS2_LSHIFT) lsh_d = 1'b1;
          if (!ext_q && byte_q == PS2_RSHIFT) rsh_d = 1'b1;
        end else begin
          if (held_match) held_v_d = 1'b0;
          if (!ext_q && byte_q == PS2_LSHIFT) lsh_d = 1'b0;
          if (!ext_q && byte_q == PS2_RSHIFT) rsh_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nextdata_n_q  <= 1'b1;
      byte_q        <= 8'h00;
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      held_v_q      <= 1'b0;
      held_ext_q    <= 1'b0;
      held_code_q   <= 8'h00;
      lsh_q         <= 1'b0;
      rsh_q         <= 1'b0;
      key_valid_q   <= 1'b0;
      key_code_q    <= 8'h00;
      key_ext_q     <= 1'b0;
      key_break_q   <= 1'b0;
      key_repeat_q  <= 1'b0;
      press_count_q <= '0;
      err_q         <= 1'b0;
    end else begin
      nextdata_n_q  <= nextdata_n_d;
      byte_q        <= byte_d;
      ext_q         <= ext_d;
      brk_q         <= brk_d;
      held_v_q      <= held_v_d;
      held_ext_q    <= held_ext_d;
      held_code_q   <= held_code_d;
      lsh_q         <= lsh_d;
      rsh_q         <= rsh_d;
      key_valid_q   <= key_valid_d;
      key_code_q    <= key_code_d;
      key_ext_q     <= key_ext_d;
      key_break_q   <= key_break_d;
      key_repeat_q  <= key_repeat_d;
      press_count_q <= press_count_d;
      err_q         <= err_d;
    end
  end

  ps2_ascii_lut u_ascii_lut (
    .code  (key_code_q),
    .ext   (key_ext_q),
    .shift (shift),
    .ascii (ascii)
  );

  assign bus.nextdata_n = nextdata_n_q;
  assign key_valid      = key_valid_q;
  assign key_code       = key_code_q;
  assign key_ext        = key_ext_q;
  assign key_break      = key_break_q;
  assign key_repeat     = key_repeat_q;
  assign shift          = lsh_q | rsh_q;
  assign press_count    = press_count_q;
  assign err            = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_scan_decoder.sv
// ============================================================================
// tb_ps2_scan_decoder : FIFO model + event-level reference model for the decoder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ps2_scan_decoder;

  typedef struct {
    logic [7:0] code;
    bit         ext;
    bit         brk;
    bit         rep;
    logic [7:0] asc;
    bit         sh;
    int         cnt;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_valid, key_ext, key_break, key_repeat, shift, err;
  logic [7:0] key_code, ascii, press_count;

  ps2_scan_decoder_if bus ();

  ps2_scan_decoder #(.CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_break   (key_break),
    .key_repeat  (key_repeat),
    .ascii       (ascii),
    .shift       (shift),
    .press_count (press_count),
    .err         (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digits  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  logic [7:0] fifo  [$];
  ev_t        exp_q [$];
  bit         m_ext, m_brk, m_held_v, m_lsh, m_rsh;
  int         m_held, m_cnt;

  function automatic logic [7:0] ref_ascii(input logic [7:0] c, input bit e, input bit s);
    if (e) return 8'h00;
    for (int i = 0; i < 26; i++)
      if (c == letters[i]) return (s ? 8'h41 : 8'h61) + 8'(i);
    for (int i = 0; i < 10; i++)
      if (c == digits[i]) return 8'h30 + 8'(i);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    return 8'h00;
  endfunction

  function automatic void model_reset();
    fifo.delete();
    exp_q.delete();
    m_ext = 0; m_brk = 0; m_held_v = 0; m_held = 0;
    m_lsh = 0; m_rsh = 0; m_cnt = 0;
  endfunction

  function automatic void push_byte(input logic [7:0] b);
    ev_t ev;
    int  key;
    fifo.push_back(b);
    if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      key = (m_ext ? 256 : 0) + int'(b);
      ev.rep = 0;
      if (!m_brk) begin
        if (m_held_v && m_held == key) ev.rep = 1;
        else begin m_cnt = (m_cnt + 1) % 256; m_held = key; m_held_v = 1; end
        if (!m_ext && b == 8'h12) m_lsh = 1;
        if (!m_ext && b == 8'h59) m_rsh = 1;
      end else begin
        if (m_held_v && m_held == key) m_held_v = 0;
        if (!m_ext && b == 8'h12) m_lsh = 0;
        if (!m_ext && b == 8'h59) m_rsh = 0;
      end
      ev.code = b;
      ev.ext  = m_ext;
      ev.brk  = m_brk;
      ev.sh   = m_lsh | m_rsh;
      ev.asc  = ref_ascii(b, m_ext, m_lsh | m_rsh);
      ev.cnt  = m_cnt;
      exp_q.push_back(ev);
      m_ext = 0;
      m_brk = 0;
    end
  endfunction

  // ---------------- upstream FIFO + pop-strobe protocol checks ----------------
  int pulses  = 0;
  int cyc     = 0;
  int last_lo = -10;
  bit prev_nd = 1'b1;

  initial begin
    bus.ready = 1'b0;
    bus.data  = 8'h00;
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      prev_nd = 1'b1;
    end else begin
      if (bus.nextdata_n == 1'b0) begin
        check("nd_width", {31'd0, prev_nd}, 32'd1);
        check("nd_gap", (cyc - last_lo >= 2) ? 32'd1 : 32'd0, 32'd1);
        if (fifo.size() == 0) check("pop_empty", 32'd1, 32'd0);
        else void'(fifo.pop_front());
        pulses++;
        last_lo = cyc;
      end
      prev_nd = bus.nextdata_n;
    end
    bus.ready = (fifo.size() > 0);
    bus.data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
  end

  // ---------------- event monitor ----------------
  bit prev_kv = 1'b0;

  always @(negedge clk) begin
    if (rst && key_valid) begin
      check("kv_pulse", {31'd0, prev_kv}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_event", 32'd1, 32'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("key_code",    {24'd0, key_code},    {24'd0, e.code});
        check("key_ext",     {31'd0, key_ext},     {31'd0, e.ext});
        check("key_break",   {31'd0, key_break},   {31'd0, e.brk});
        check("key_repeat",  {31'd0, key_repeat},  {31'd0, e.rep});
        check("ascii",       {24'd0, ascii},       {24'd0, e.asc});
        check("shift",       {31'd0, shift},       {31'd0, e.sh});
        check("press_count", {24'd0, press_count}, 32'(e.cnt));
      end
    end
    prev_kv = rst && key_valid;
  end

  // ---------------- stimulus ----------------
  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (fifo.size() == 0 && exp_q.size() == 0) begin done = 1; break; end
    end
    check("drain_timeout", {31'd0, done}, 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic push_list(input logic [7:0] b [$]);
    foreach (b[i]) push_byte(b[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_nd"},    {31'd0, bus.nextdata_n}, 32'd1);
    check({tag, "_zero"},  {19'd0, key_valid, key_code, key_ext, key_break, key_repeat, shift, err},
          32'd0);
    check({tag, "_ascii"}, {24'd0, ascii}, 32'd0);
    check({tag, "_count"}, {24'd0, press_count}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    model_reset();
    #1 check_reset_outputs("rst_async");
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int p0;
    logic [7:0] pool [12] = '{8'h1C, 8'h32, 8'h12, 8'h59, 8'hE0, 8'hF0,
                              8'h75, 8'h29, 8'h5A, 8'h45, 8'h16, 8'h1C};
    bus.overflow = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_init");
    rst = 1'b1;

    // make / break / make
    p0 = pulses;
    push_list('{8'h1C, 8'hF0, 8'h1C});
    drain();
    check("t1_pulses", 32'(pulses - p0), 32'd3);
    check("t1_count", {24'd0, press_count}, 32'd1);

    // typematic
    push_list('{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C});
    drain();
    check("typ_count", {24'd0, press_count}, 32'd3);

    // shift
    push_list('{8'h12, 8'h1C, 8'hF0, 8'h12, 8'h1C});
    drain();
    check("sh_shift", {31'd0, shift}, 32'd0);
    check("sh_ascii", {24'd0, ascii}, 32'h61);

    // extended
    push_list('{8'hE0, 8'h75, 8'hF0, 8'hE0, 8'h75});
    drain();
    check("ext_flags", {30'd0, key_ext, key_break}, 32'd3);
    check("ext_code",  {24'd0, key_code}, 32'h75);
    check("ext_ascii", {24'd0, ascii}, 32'h00);

    // reset after a consumed break prefix
    push_byte(8'hF0);
    drain();
    do_reset();
    push_byte(8'h1C);
    drain();
    check("post_rst_break", {31'd0, key_break}, 32'd0);
    check("post_rst_count", {24'd0, press_count}, 32'd1);

    // sticky overflow
    @(negedge clk) bus.overflow = 1'b1;
    @(negedge clk) bus.overflow = 1'b0;
    check("err_set", {31'd0, err}, 32'd1);
    repeat (10) @(negedge clk);
    check("err_sticky", {31'd0, err}, 32'd1);
    do_reset();
    check("err_cleared", {31'd0, err}, 32'd0);

    // counter wrap
    for (int i = 0; i < 256; i++) push_byte((i % 2 == 0) ? 8'h1C : 8'h32);
    drain();
    check("wrap_count", {24'd0, press_count}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) push_byte(8'($urandom_range(0, 255)));
      else push_byte(pool[$urandom_range(0, 11)]);
      if ($urandom_range(0, 15) == 0) drain();
    end
    drain();
    check("rand_count", {24'd0, press_count}, 32'(m_cnt));
    check("rand_shift", {31'd0, shift}, {31'd0, m_lsh | m_rsh});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
